decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/operand width.
REQ-002 SHALL have parameter NREG, default 16, meaning register count, addressed by 4 bits.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning instr is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning decode accepts instr; equals !halted.
REQ-007 SHALL have port instr, input, 16, with fields op[15:12], rd[11:8], rs1[7:4], rs2[3:0], imm8[7:0].
REQ-008 SHALL have port flush, input, 1, driven by execute do_branch.
REQ-009 SHALL have ports wb_en (input, 1), wb_addr (input, 4) and wb_data (input, DATA_W), meaning the register-file write port.
REQ-010 SHALL have outputs is_add, is_sub, is_and, is_or, is_gt, is_eq, is_mem_write, is_reg_write, is_halt and is_branch, each 1 bit and one-hot-or-zero among the ALU bits.
REQ-011 SHALL have outputs val1, val2 and val3, each DATA_W wide, meaning operands and destination/target.
REQ-012 SHALL have outputs is_val1_data_hazard, is_val2_data_hazard and is_mem_data_hazard, each 1 bit, meaning forwarding selects for execute.

Function
REQ-013 SHALL accept an instruction when in_valid && in_ready && !flush; all outputs SHALL be registered with 1-cycle latency.
REQ-014 SHALL decode op 0 as NOP and ops 1-6 as ADD/SUB/AND/OR/GT/EQ, with val1=R[rs1], val2=R[rs2], val3=rd and is_reg_write=1.
REQ-015 SHALL decode op 7 LDI as is_add, val1=zero-extended imm8, val2=0, val3=rd and is_reg_write=1.
REQ-016 SHALL decode op 8 ST as is_mem_write, val1=R[rs1] (address), val2=R[rs2] (data), with no register write.
REQ-017 SHALL decode op 9 BNZ as is_branch and is_or, with val1=R[rs1], val2=0 and val3=zero-extended imm8 (target).
REQ-018 SHALL decode op 15 HALT as is_halt=1; it SHALL set sticky halted, after which in_ready=0 and every following output is a bubble.
REQ-019 SHALL decode ops 10-14 as a bubble.
REQ-020 SHALL define a bubble as all is_* = 0, val1 = val2 = val3 = 0 and all hazard bits = 0.
REQ-021 SHALL emit a bubble in any cycle with no accepted instruction.
REQ-022 SHALL hold register file R[NREG] of DATA_W bits; R[0] SHALL read as 0 and writes to R[0] SHALL be ignored.
REQ-023 SHALL keep a 2-entry destination history: d1 is the dest of the instruction now in execute, d2 the one a stage beyond; each entry holds {valid, addr}.
REQ-024 SHALL shift the history every cycle (d2<=d1; d1<=new dest, valid only if is_reg_write).
REQ-025 SHALL set is_valN_data_hazard when rsN is nonzero, matches a valid d1 or d2, and the op reads rsN.
REQ-026 SHALL set is_mem_data_hazard when a flagged operand matches d2 but not d1; a d1 match SHALL take priority.
REQ-027 SHALL, on flush, drive the next output to a bubble, drop the instruction presented that cycle, and clear d1.valid; d2 is kept.
REQ-028 SHALL, when flush and HALT decode coincide, let flush win so halted is not set.

Reset
REQ-029 SHALL, with rst high, asynchronously clear all outputs to the bubble, clear d1/d2 valid and clear halted (in_ready=1).
REQ-030 SHALL leave register file contents unaffected by reset, except that R[0] is always 0.
REQ-031 SHALL, on reset mid-operation, discard any in-flight instruction; no write is performed for it.

Configuration
REQ-032 SHALL provide macro DECODE_WB_BYPASS_EN.
REQ-033 SHALL, when DECODE_WB_BYPASS_EN is defined, return wb_data for a read of wb_addr in the same cycle wb_en is high.
REQ-034 SHALL, without DECODE_WB_BYPASS_EN, return the old register value for such a read; the bench SHALL expect the old value.

Verification
REQ-035 SHALL pass: wb R1=5, R2=3, then ADD rd=3 rs1=1 rs2=2 -> next cycle is_add=1, val1=5, val2=3, val3=3, is_reg_write=1, no hazard bits.
REQ-036 SHALL pass: LDI R4=7 then ADD R5=R4+R4 back-to-back -> second output has is_val1_data_hazard=1, is_val2_data_hazard=1 and is_mem_data_hazard=0.
REQ-037 SHALL pass: LDI R4, then NOP, then SUB R6=R4-R0 -> is_val1_data_hazard=1, is_mem_data_hazard=1 and is_val2_data_hazard=0.
REQ-038 SHALL pass: BNZ presented with flush=1 -> next output is a bubble, and a following ADD reading the prior d1 dest shows no d1 hazard.
REQ-039 SHALL pass: HALT accepted -> is_halt=1 for one cycle, in_ready=0 thereafter; rst pulse -> in_ready=1 with outputs at the bubble.
REQ-040 SHALL pass: wb_en=1, wb_addr=2, wb_data=9 while decoding ADD reading R2 (old value 3) -> val1=9 with DECODE_WB_BYPASS_EN, val1=3 without.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered decode with register file, dest-history hazard flags and sticky halt.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle wb_data to register reads.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              is_add,
  output logic              is_sub,
  output logic              is_and,
  output logic              is_or,
  output logic              is_gt,
  output logic              is_eq,
  output logic              is_mem_write,
  output logic              is_reg_write,
  output logic              is_halt,
  output logic              is_branch,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] val3,
  output logic              is_val1_data_hazard,
  output logic              is_val2_data_hazard,
  output logic              is_mem_data_hazard
);
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] r1, r2, n_v1, n_v2, n_v3;
  logic [3:0] op, rd, rs1, rs2, d1_a, d2_a;
  logic halted, d1_v, d2_v, acc, alu_op, ldi, st, bnz, use1, use2;
  logic m11, m12, m21, m22, n_h1, n_h2, n_mem;
  assign {op, rd, rs1, rs2} = instr;
  assign in_ready = !halted;
  assign acc = in_valid && in_ready && !flush;
`ifdef DECODE_WB_BYPASS_EN
  assign r1 = rs1 == 4'd0 ? '0 : (wb_en && wb_addr == rs1) ? wb_data : rf[rs1];
  assign r2 = rs2 == 4'd0 ? '0 : (wb_en && wb_addr == rs2) ? wb_data : rf[rs2];
`else
  assign r1 = rs1 == 4'd0 ? '0 : rf[rs1];
  assign r2 = rs2 == 4'd0 ? '0 : rf[rs2];
`endif
  // register file write port; R0 is never stored and reads as zero
  always_ff @(posedge clk)
    if (wb_en && wb_addr != 4'd0) rf[wb_addr] <= wb_data;
  // classify the presented instruction, select operands and flag hazards against d1/d2
  always_comb begin
    alu_op = acc && op >= 4'd1 && op <= 4'd6;
    ldi = acc && op == 4'd7;
    st = acc && op == 4'd8;
    bnz = acc && op == 4'd9;
    use1 = alu_op || st || bnz;
    use2 = alu_op || st;
    m11 = d1_v && d1_a == rs1;
    m12 = d2_v && d2_a == rs1;
    m21 = d1_v && d1_a == rs2;
    m22 = d2_v && d2_a == rs2;
    n_h1 = use1 && rs1 != 4'd0 && (m11 || m12);
    n_h2 = use2 && rs2 != 4'd0 && (m21 || m22);
    n_mem = (n_h1 && !m11) || (n_h2 && !m21);
    n_v1 = ldi ? DATA_W'(instr[7:0]) : use1 ? r1 : '0;
    n_v2 = use2 ? r2 : '0;
    n_v3 = (alu_op || ldi) ? DATA_W'(rd) : bnz ? DATA_W'(instr[7:0]) : '0;
  end
  // output register, destination history shift and sticky halt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {is_add, is_sub, is_and, is_or, is_gt, is_eq} <= '0;
      {is_mem_write, is_reg_write, is_halt, is_branch} <= '0;
      {is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard} <= '0;
      val1 <= '0;
      val2 <= '0;
      val3 <= '0;
      halted <= 1'b0;
      {d1_v, d1_a, d2_v, d2_a} <= '0;
    end else begin
      is_add <= alu_op && op == 4'd1 || ldi;
      is_sub <= alu_op && op == 4'd2;
      is_and <= alu_op && op == 4'd3;
      is_or <= alu_op && op == 4'd4 || bnz;
      is_gt <= alu_op && op == 4'd5;
      is_eq <= alu_op && op == 4'd6;
      is_mem_write <= st;
      is_reg_write <= alu_op || ldi;
      is_halt <= acc && op == 4'd15;
      is_branch <= bnz;
      is_val1_data_hazard <= n_h1;
      is_val2_data_hazard <= n_h2;
      is_mem_data_hazard <= n_mem;
      val1 <= n_v1;
      val2 <= n_v2;
      val3 <= n_v3;
      halted <= halted || (acc && op == 4'd15);
      d1_v <= alu_op || ldi;
      d1_a <= rd;
      d2_v <= d1_v;
      d2_a <= d1_a;
    end
endmodule
